// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit: FSM states,
// Booth recoding selections and the iteration-count helper.
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    B_ZERO,
    B_POS1,
    B_POS2,
    B_NEG1,
    B_NEG2
  } booth_sel_t;

  // Radix-4 steps needed to consume a (p+2)-bit extended multiplier.
  function automatic logic [5:0] iter_count(input int p);
    return 6'((p + 2) / 2);
  endfunction

endpackage

// File: rtl/booth_mult_unit_if.sv
// Operand/result bundle of the Booth multiplier; the master issues
// operations, the slave (the multiplier) returns busy/done/product.
interface booth_mult_unit_if #(
  parameter int PARALLELISM = 32
);
  logic                       start;
  logic                       usigned;
  logic [PARALLELISM-1:0]     multiplicand;
  logic [PARALLELISM-1:0]     multiplier;
  logic                       busy;
  logic                       done;
  logic [2*PARALLELISM-1:0]   product;

  modport master (
    output start, usigned, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, usigned, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: maps the window {q[1], q[0], q[-1]} to a
// partial-product selection.
module booth_recoder
  import mdu_pkg::*;
(
  input  logic [2:0]  i_window,
  output booth_sel_t  o_sel
);

  // NOTE: every output of a combinational block gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_sel = B_ZERO;
    case (i_window)
      3'b001, 3'b010: o_sel = B_POS1;
      3'b011:         o_sel = B_POS2;
      3'b100:         o_sel = B_NEG2;
      3'b101, 3'b110: o_sel = B_NEG1;
      default:        o_sel = B_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mult_unit.sv
// Sequential radix-4 Booth multiplier: retires two multiplier bits per
// cycle and returns a 2P-bit product with a one-cycle done pulse.
module booth_mult_unit
  import mdu_pkg::*;
#(
  parameter int PARALLELISM = 32
) (
  input  logic               clk,
  input  logic               rst,
  booth_mult_unit_if.slave   bus
);

  localparam int P  = PARALLELISM;
  localparam int QW = P + 2;
  localparam int AW = P + 4;

  state_t            r_state;
  state_t            w_state_next;
  logic [AW-1:0]     r_a;
  logic [QW-1:0]     r_qr;
  logic [QW-1:0]     r_m;
  logic              r_qm1;
  logic [5:0]        r_cnt;
  logic [2*P-1:0]    r_product;

  booth_sel_t        w_sel;
  logic [AW-1:0]     w_op;
  logic              w_neg;
  logic [AW-1:0]     w_sum;
  logic [AW-1:0]     w_a_next;
  logic [QW-1:0]     w_qr_next;
  logic [QW-1:0]     w_m_ext;
  logic [QW-1:0]     w_q_ext;
  logic              w_last;

  // Unsigned operands are zero-extended, signed ones sign-extended.
  assign w_m_ext = bus.usigned ? {2'b00, bus.multiplicand}
                               : {{2{bus.multiplicand[P-1]}}, bus.multiplicand};
  assign w_q_ext = bus.usigned ? {2'b00, bus.multiplier}
                               : {{2{bus.multiplier[P-1]}}, bus.multiplier};

  booth_recoder u_recoder (
    .i_window (r_qr[1:0] == 2'b00 ? {2'b00, r_qm1} : {r_qr[1:0], r_qm1}),
    .o_sel    (w_sel)
  );

  // Negative selections use ones' complement with a carry-in of one.
  always_comb begin
    w_op  = '0;
    w_neg = 1'b0;
    case (w_sel)
      B_POS1: w_op = {{2{r_m[QW-1]}}, r_m};
      B_POS2: w_op = {r_m[QW-1], r_m, 1'b0};
      B_NEG1: begin
        w_op  = ~{{2{r_m[QW-1]}}, r_m};
        w_neg = 1'b1;
      end
      B_NEG2: begin
        w_op  = ~{r_m[QW-1], r_m, 1'b0};
        w_neg = 1'b1;
      end
      default: w_op = '0;
    endcase
  end

  assign w_sum     = r_a + w_op + AW'(w_neg);
  assign w_a_next  = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
  assign w_qr_next = {w_sum[1:0], r_qr[QW-1:2]};
  assign w_last    = (r_cnt == 6'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_qr      <= '0;
      r_m       <= '0;
      r_qm1     <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_m   <= w_m_ext;
            r_qr  <= w_q_ext;
            r_a   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= iter_count(P);
          end
        end
        RUN: begin
          r_a   <= w_a_next;
          r_qr  <= w_qr_next;
          r_qm1 <= r_qr[1];
          r_cnt <= r_cnt - 6'd1;
          // Capture on the final step so the product is valid in DONE.
          if (w_last) r_product <= {w_a_next[P-3:0], w_qr_next};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = (r_state == DONE);
  assign bus.product = r_product;

endmodule

// File: tb/tb_booth_mult_unit.sv
// Self-checking bench for booth_mult_unit: a latency/product model is
// compared every cycle, plus literal products for the corner cases.
module tb_booth_mult_unit;

  localparam int P   = 32;
  localparam int LAT = (P + 2) / 2 + 1;

  logic clk;
  logic rst;
  logic chk_en = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  booth_mult_unit_if #(.PARALLELISM(P)) bus ();

  booth_mult_unit #(.PARALLELISM(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic u, input logic [31:0] m, input logic [31:0] q);
    longint sm;
    longint sq;
    logic [63:0] um;
    logic [63:0] uq;
    if (u) begin
      um = {32'd0, m};
      uq = {32'd0, q};
      return um * uq;
    end
    sm = longint'($signed(m));
    sq = longint'($signed(q));
    return 64'(sm * sq);
  endfunction

  // Behavioural model: an accepted start makes the unit busy for LAT
  // cycles, the last of which is the done cycle carrying the new product.
  int          m_left = 0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_prod <= '0;
    end else if (m_left == 0) begin
      if (bus.start === 1'b1) begin
        m_left <= LAT;
        m_pend <= ref_mul(bus.usigned, bus.multiplicand, bus.multiplier);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_prod <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", 64'(bus.busy), 64'(m_left != 0));
      check("model_done", 64'(bus.done), 64'(m_left == 1));
      check("model_product", bus.product, m_prod);
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 40) check("done_timeout", 64'(cyc), 64'd0);
  endtask

  task automatic run_op(input string nm, input logic u, input logic [31:0] m,
                        input logic [31:0] q, input logic [63:0] exp);
    int cyc;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.usigned      = u;
    bus.multiplicand = m;
    bus.multiplier   = q;
    @(negedge clk);
    bus.start        = 1'b0;
    bus.usigned      = 1'($urandom_range(0, 1));
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    wait_done(cyc);
    check({nm, "_latency"}, 64'(cyc), 64'(LAT));
    check(nm, bus.product, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int busy_cnt;
    int dones;
    logic        u;
    logic [31:0] m;
    logic [31:0] q;

    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.usigned      = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_product", bus.product, 64'd0);
    rst = 1'b0;

    run_op("signed_small", 1'b0, 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("unsigned_max", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("signed_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_op("signed_min_sq", 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("signed_min_max", 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
    run_op("zero_s", 1'b0, 32'd0, 32'hDEAD_BEEF, 64'd0);
    run_op("zero_u", 1'b1, 32'd0, 32'hDEAD_BEEF, 64'd0);

    // Handshake: start held high through RUN/DONE must not retrigger early.
    @(negedge clk);
    bus.start = 1'b1; bus.usigned = 1'b0;
    bus.multiplicand = 32'd6; bus.multiplier = 32'd7;
    @(negedge clk);
    bus.multiplicand = 32'd2; bus.multiplier = 32'd2;
    busy_cnt = 0;
    dones    = 0;
    for (int i = 0; i < LAT + 1; i++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        dones++;
        if (dones == 1) begin
          check("hs_product_42", bus.product, 64'd42);
          check("hs_latency", 64'(i + 1), 64'(LAT));
        end
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("hs_busy_cycles", 64'(busy_cnt), 64'(LAT));
    check("hs_single_done", 64'(dones), 64'd1);
    check("hs_second_busy", 64'(bus.busy), 64'd1);
    wait_done(cyc);
    check("hs_product_4", bus.product, 64'd4);

    // Reset in the middle of an operation aborts it silently.
    @(negedge clk);
    bus.start = 1'b1; bus.usigned = 1'b0;
    bus.multiplicand = 32'd5; bus.multiplier = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_product", bus.product, 64'd0);
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clk);
    end
    check("rst_no_done", 64'(dones), 64'd0);
    run_op("rst_recover", 1'b0, 32'd5, 32'd5, 64'd25);

    // Random operands, both signedness modes, with corners mixed in.
    for (int i = 0; i < 1000; i++) begin
      u = 1'($urandom_range(0, 1));
      m = $urandom;
      q = $urandom;
      case ($urandom_range(0, 9))
        0: m = 32'h8000_0000;
        1: q = 32'hFFFF_FFFF;
        2: m = 32'h7FFF_FFFF;
        3: q = 32'd0;
        default: ;
      endcase
      run_op("random", u, m, q, ref_mul(u, m, q));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/booth_mult_unit.md
Name: booth_mult_unit

Overview:
Sequential radix-4 Booth multiplier, the multiply counterpart of the SRT divider path in the multiply/divide unit.
- Accepts two P-bit operands (signed or unsigned) on a start pulse.
- Retires two multiplier bits per cycle.
- Returns a 2P-bit product with a one-cycle done pulse.
- Shares the operand/usigned convention of the divider so the unit top can mux results.

Parameters:
PARALLELISM, 32, operand width P; must be even and ≥4.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request; sampled only in IDLE
usigned  in  1  1 = operands unsigned, 0 = two's complement; captured with start
multiplicand  in  P  operand M; captured with start
multiplier  in  P  operand Q; captured with start
busy  out  1  high from cycle after accepted start until done cycle inclusive
done  out  1  one-cycle pulse; product valid from this cycle
product  out  2P  result; held until next accepted start

Behaviour:
- Reset: synchronous, active-high.
  - state=IDLE; busy=0, done=0, product=0; counter=0.
  - rst mid-operation aborts with no done pulse; the next cycle is IDLE.
- Operand extension to P+2 bits: usigned ? zero-extend : sign-extend. Same rule for M and Q.
- Datapath registers:
  - A: P+4 bits, accumulator.
  - Qr: P+2 bits, multiplier shift register.
  - qm1: 1 bit, Booth guard bit.
  - Mr: P+2 bits, multiplicand.
  - cnt: 6 bits.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start=1 → load Mr=ext(M), Qr=ext(Q), A=0, qm1=0, cnt=(P+2)/2, and go to RUN.
  - start=0 → stay in IDLE.
- RUN, one Booth step per cycle:
  - Recode {Qr[1:0],qm1}: 000/111→0; 001/010→+M; 011→+2M; 100→−2M; 101/110→−M.
  - Operand is Mr sign-extended to P+4 (2M = sign-extended left shift by 1). Negation is ones'-complement plus carry-in 1.
  - A' = A + operand, modulo 2^(P+4).
  - Arithmetic right shift of {A',Qr,qm1} by 2: qm1←Qr[1], Qr←{A'[1:0],Qr[P+1:2]}, A←A' sign-shifted by 2.
  - cnt decrements. When cnt reaches 1 in RUN, the step executes and the FSM goes to DONE.
- DONE:
  - product←{A,Qr}[2P-1:0]; done=1 for this cycle only.
  - Next state is IDLE; a start asserted in DONE is ignored.
- Latency:
  - start sampled high at edge k; RUN occupies cycles k+1 … k+(P+2)/2; done is high in cycle k+(P+2)/2+1.
  - For P=32 that is 17 RUN cycles, with done on the 18th cycle after the start edge.
- start during RUN/DONE is ignored; operand inputs may change freely after acceptance.
- product changes only in DONE and on reset. busy=1 in RUN and DONE.
- Overflow cannot occur: a (P+2)×(P+2) product fits within {A,Qr}. The top bits are discarded by truncation to 2P, which is exact for both signed and unsigned P-bit inputs.

Decomposition:
- Package mdu_pkg holds:
  - typedef enum state_t {IDLE,RUN,DONE};
  - typedef enum booth_sel_t {B_ZERO,B_POS1,B_POS2,B_NEG1,B_NEG2};
  - function iter_count(P) = (P+2)/2.
- Sub-module booth_recoder: combinational, 3-bit window in → booth_sel_t out. Reused later by a radix-4 multiply-accumulate variant.
- Adder and shift register come from existing adder/shiftRegister primitives.

Test Plan:
- Signed small: usigned=0, M=3, Q=0xFFFF_FFFB (−5) → done at start+18, product=0xFFFF_FFFF_FFFF_FFF1.
- Unsigned max: usigned=1, M=Q=0xFFFF_FFFF → product=0xFFFF_FFFE_0000_0001. Repeat with usigned=0 → product=0x0000_0000_0000_0001.
- Signed corner: usigned=0, M=Q=0x8000_0000 → product=0x4000_0000_0000_0000. M=0x8000_0000, Q=0x7FFF_FFFF → 0xC000_0000_8000_0000.
- Handshake:
  - Pulse start with M=6, Q=7, then hold start=1 with M=2, Q=2 through RUN/DONE → exactly one done, product=42.
  - The second operation starts from the IDLE cycle after done, and its product is 4.
  - busy=1 for 18 cycles.
- Reset mid-op: start M=Q=5, assert rst at RUN cycle 8 → next cycle busy=0, done=0, product=0, and no done pulse ever follows. A fresh start then gives 25.
- Zero/back-to-back: M=0, Q=0xDEAD_BEEF → product=0. Random 1000 signed/unsigned pairs compared against a reference model; product is stable between done pulses.
